seq_stage_ctrl: RTL and testbench
=================================

Name: seq_stage_ctrl

Overview:
Multi-cycle sequencer for the SEQ Y86-64 datapath. It steps each instruction through fetch, decode, execute, memory, writeback and PC-update, raising one stage enable per cycle. It gates the condition-code write so that only OPq updates ZF/SF/OF, and waits on the data-memory handshake. It also tracks processor status (AOK/HLT/ADR/INS) and keeps cycle and retired-instruction counters.

Parameters:
CNT_W, 32, width of cycle_count and instr_count
MEM_TIMEOUT, 15, maximum wait cycles in MEMORY for mem_ready before ADR fault (must be at least 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin execution from IDLE; ignored in all other states
icode  input  4  instruction code from fetch; sampled at the end of FETCH
imem_error  input  1  instruction fetch address error; sampled at the end of FETCH
mem_ready  input  1  data memory access complete
dmem_error  input  1  data memory address error; valid when mem_ready=1
fetch_en  output  1  fetch stage enable
decode_en  output  1  decode/register-read enable
exec_en  output  1  execute stage (ALU) enable
mem_en  output  1  data memory request; held until mem_ready or timeout
wb_en  output  1  register-file write enable
pc_en  output  1  PC register update enable
cc_we  output  1  condition-code register write strobe
cur_icode  output  4  latched icode of the instruction in flight
stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
busy  output  1  high in every state except IDLE and HALT
cycle_count  output  CNT_W  cycles spent outside IDLE/HALT; saturates at all-ones
instr_count  output  CNT_W  retired instructions; saturates at all-ones

Behaviour:
- Reset (asynchronous, any state, including mid-instruction):
  - state=IDLE; all enables=0; cur_icode=0; stat=AOK; both counters=0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- Enables are Moore outputs decoded from state. At most one stage enable is high in any cycle:
  - fetch_en in FETCH, decode_en in DECODE, exec_en in EXECUTE.
  - mem_en in MEMORY, only when cur_icode is one of {4,5,8,9,10,11}.
  - wb_en in WRITEBACK; pc_en in PCUPD.
- cc_we=1 only in EXECUTE when cur_icode=6. This is a single-cycle pulse per OPq; cc_we=0 for every other icode, including 2 and 7.
- IDLE -> FETCH on start=1.
- FETCH (end of cycle): latch cur_icode<=icode, then evaluate in priority order:
  - imem_error=1 -> HALT, stat=ADR.
  - else icode>11 -> HALT, stat=INS.
  - else icode=0 -> HALT, stat=HLT, instr_count increments (halt retires).
  - else -> DECODE.
- DECODE -> EXECUTE -> MEMORY, one cycle each.
- MEMORY:
  - Non-memory icodes (1,2,3,6,7): one cycle, no handshake, then WRITEBACK.
  - Memory icodes: mem_en stays high until mem_ready=1. In that cycle:
    - dmem_error=1 -> HALT, stat=ADR, no WRITEBACK, no PCUPD.
    - dmem_error=0 -> WRITEBACK.
  - Wait counter starts at 0 on MEMORY entry and increments each cycle mem_ready=0. When it reaches MEM_TIMEOUT with mem_ready still 0 -> HALT, stat=ADR.
  - mem_ready arriving in the same cycle the limit is hit wins, i.e. the access completes.
- WRITEBACK -> PCUPD. PCUPD -> FETCH, with instr_count incrementing.
- Latency: 6 cycles per non-memory instruction (FETCH through PCUPD); 6+N for a memory instruction where N is the count of mem_ready=0 cycles.
- HALT is terminal: all enables 0, busy=0, stat, counters and cur_icode frozen. Only rst exits HALT; start has no effect.
- cycle_count increments in every cycle the state is not IDLE or HALT (FETCH through PCUPD, including memory wait cycles). The cycle that transitions into HALT counts.
- stat changes only on a transition into HALT; it is AOK at all other times.
- mem_ready and dmem_error are ignored outside MEMORY.

Test Plan:
- Reset then idle: assert rst during random state -> all enables 0, stat=1, counters 0, busy=0; start with icode=3 -> fetch_en, decode_en, exec_en, (no mem_en), wb_en, pc_en on six consecutive cycles, instr_count=1, cycle_count=6.
- OPq: icode=6 -> cc_we=1 exactly in the exec_en cycle; repeat with icode=2 and icode=7 -> cc_we stays 0.
- mrmovq handshake: icode=5, mem_ready low 3 cycles then high -> mem_en high 4 cycles, wb_en next cycle, cycle_count=9 after PCUPD.
- Memory faults: icode=10 with mem_ready+dmem_error=1 -> HALT, stat=3, no wb_en/pc_en; icode=4 with mem_ready never high -> HALT stat=3 after MEM_TIMEOUT wait cycles.
- Halt/invalid: icode=0 -> HALT, stat=2, instr_count +1; icode=12 -> stat=4, instr_count unchanged; imem_error with icode=0 -> stat=3; start in HALT -> no change.
- Reset mid-operation: rst asserted in MEMORY while mem_en high -> mem_en drops immediately (async), state IDLE; subsequent start runs normally.

Source files
------------

// File: rtl/seq_stage_ctrl.sv
// rtl/seq_stage_ctrl.sv - multi-cycle stage sequencer for the SEQ Y86-64 datapath
module seq_stage_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             mem_ready,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic             cc_we,
  output logic [3:0]       cur_icode,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_t;

  state_t          state, state_n;
  logic [2:0]      stat_n;
  logic [3:0]      icode_n;
  logic [WW-1:0]   wait_cnt, wait_n;
  logic            retire;
  logic            is_mem;

  assign is_mem = cur_icode inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      stat        <= STAT_AOK;
      cur_icode   <= 4'd0;
      wait_cnt    <= '0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state     <= state_n;
      stat      <= stat_n;
      cur_icode <= icode_n;
      wait_cnt  <= wait_n;
      if (busy && cycle_count != {CNT_W{1'b1}})
        cycle_count <= cycle_count + 1'b1;
      if (retire && instr_count != {CNT_W{1'b1}})
        instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    stat_n    = stat;
    icode_n   = cur_icode;
    wait_n    = wait_cnt;
    retire    = 1'b0;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    pc_en     = 1'b0;
    cc_we     = 1'b0;
    busy      = (state != S_IDLE) && (state != S_HALT);
    case (state)
      S_IDLE: if (start) state_n = S_FETCH;
      S_FETCH: begin
        fetch_en = 1'b1;
        icode_n  = icode;
        if (imem_error) begin
          state_n = S_HALT;
          stat_n  = STAT_ADR;
        end else if (icode > 4'd11) begin
          state_n = S_HALT;
          stat_n  = STAT_INS;
        end else if (icode == 4'd0) begin
          state_n = S_HALT;
          stat_n  = STAT_HLT;
          retire  = 1'b1;
        end else begin
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        decode_en = 1'b1;
        state_n   = S_EXECUTE;
      end
      S_EXECUTE: begin
        exec_en = 1'b1;
        cc_we   = (cur_icode == 4'd6);
        wait_n  = '0;
        state_n = S_MEMORY;
      end
      S_MEMORY: begin
        if (is_mem) begin
          mem_en = 1'b1;
          // A completion arriving on the last allowed wait cycle still wins.
          if (mem_ready) begin
            if (dmem_error) begin
              state_n = S_HALT;
              stat_n  = STAT_ADR;
            end else begin
              state_n = S_WRITEBACK;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state_n = S_HALT;
            stat_n  = STAT_ADR;
          end else begin
            wait_n = wait_cnt + 1'b1;
          end
        end else begin
          state_n = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        wb_en   = 1'b1;
        state_n = S_PCUPD;
      end
      S_PCUPD: begin
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb/tb_seq_stage_ctrl.sv - randomized self-checking bench for seq_stage_ctrl
module tb_seq_stage_ctrl;
  localparam int CNT_W = 32;
  localparam int MEM_TIMEOUT = 15;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] icode = 4'd0;
  logic imem_error = 1'b0, mem_ready = 1'b0, dmem_error = 1'b0;
  logic fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_we, busy;
  logic [3:0] cur_icode;
  logic [2:0] stat;
  logic [CNT_W-1:0] cycle_count, instr_count;

  int n_tests = 0, n_fail = 0;
  int m_cycles = 0, m_instr = 0;
  logic [2:0] m_stat = 3'd1;
  bit m_halted = 0;

  typedef struct packed {
    logic [6:0] en;
    logic       rdy;
    logic       der;
  } cyc_t;

  seq_stage_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .imem_error(imem_error),
    .mem_ready(mem_ready), .dmem_error(dmem_error), .fetch_en(fetch_en),
    .decode_en(decode_en), .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en),
    .pc_en(pc_en), .cc_we(cc_we), .cur_icode(cur_icode), .stat(stat), .busy(busy),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ens();
    return {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_we};
  endfunction

  function automatic bit is_mem_op(input logic [3:0] ic);
    return (ic == 4 || ic == 5 || (ic >= 8 && ic <= 11));
  endfunction

  task automatic check_counters(input string tag);
    n_tests++;
    if (cycle_count !== CNT_W'(m_cycles) || instr_count !== CNT_W'(m_instr)) begin
      n_fail++;
      $display("FAIL %s counters: cycle=%0d instr=%0d, expected cycle=%0d instr=%0d",
               tag, cycle_count, instr_count, m_cycles, m_instr);
    end
  endtask

  // Asserts rst mid-cycle and checks the asynchronous clear before any clock edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (ens() !== 7'b0 || busy !== 1'b0 || stat !== 3'd1 || cycle_count !== '0 ||
        instr_count !== '0 || cur_icode !== 4'd0) begin
      n_fail++;
      $display("FAIL %s reset: en=%b busy=%b stat=%0d cyc=%0d ins=%0d icode=%0d, expected all zero stat=1",
               tag, ens(), busy, stat, cycle_count, instr_count, cur_icode);
    end
    @(negedge clk);
    rst = 1'b0;
    m_cycles = 0; m_instr = 0; m_stat = 3'd1; m_halted = 0;
  endtask

  task automatic start_run(input string tag);
    n_tests++;
    if (ens() !== 7'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: en=%b busy=%b, expected en=0 busy=0", tag, ens(), busy);
    end
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  // Builds the expected per-cycle enable trace for one instruction from the
  // stage rules, then walks the DUT through it cycle by cycle.
  task automatic run_instr(input string tag, input logic [3:0] ic, input bit ierr,
                           input int nwait, input bit derr);
    cyc_t seq[$];
    logic [2:0] hs = 3'd0;
    bit retire = 0;
    seq.push_back('{7'b1000000, 1'($urandom), 1'($urandom)});
    if (ierr) hs = 3'd3;
    else if (ic > 11) hs = 3'd4;
    else if (ic == 0) begin hs = 3'd2; retire = 1; end
    else begin
      seq.push_back('{7'b0100000, 1'($urandom), 1'($urandom)});
      seq.push_back('{(ic == 6) ? 7'b0010001 : 7'b0010000, 1'($urandom), 1'($urandom)});
      if (is_mem_op(ic)) begin
        for (int k = 0; k < nwait && k < MEM_TIMEOUT; k++)
          seq.push_back('{7'b0001000, 1'b0, 1'($urandom)});
        if (nwait >= MEM_TIMEOUT) hs = 3'd3;
        else begin
          seq.push_back('{7'b0001000, 1'b1, derr});
          if (derr) hs = 3'd3;
        end
      end else begin
        seq.push_back('{7'b0000000, 1'($urandom), 1'($urandom)});
      end
      if (hs == 0) begin
        seq.push_back('{7'b0000100, 1'($urandom), 1'($urandom)});
        seq.push_back('{7'b0000010, 1'($urandom), 1'($urandom)});
        retire = 1;
      end
    end
    foreach (seq[i]) begin
      n_tests++;
      if (ens() !== seq[i].en || busy !== 1'b1 || stat !== 3'd1 ||
          (i > 0 && cur_icode !== ic)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: en=%b busy=%b stat=%0d icode=%0d, expected en=%b busy=1 stat=1 icode=%0d",
                 tag, i, ens(), busy, stat, cur_icode, seq[i].en, ic);
      end
      icode      = (i == 0) ? ic : 4'($urandom);
      imem_error = (i == 0) ? ierr : 1'($urandom);
      mem_ready  = seq[i].rdy;
      dmem_error = seq[i].der;
      @(posedge clk); @(negedge clk);
    end
    m_cycles += seq.size();
    if (retire) m_instr++;
    n_tests++;
    if (hs != 0) begin
      m_halted = 1; m_stat = hs;
      if (ens() !== 7'b0 || busy !== 1'b0 || stat !== hs) begin
        n_fail++;
        $display("FAIL %s halt: en=%b busy=%b stat=%0d, expected en=0 busy=0 stat=%0d",
                 tag, ens(), busy, stat, hs);
      end
    end else if (ens() !== 7'b1000000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s next fetch: en=%b busy=%b, expected en=1000000 busy=1", tag, ens(), busy);
    end
    check_counters(tag);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    start_run("rst_pre");
    for (int i = 0; i < int'($urandom_range(2, 12)); i++) begin
      icode = 4'($urandom_range(1, 11)); imem_error = 1'b0; mem_ready = 1'($urandom);
      @(posedge clk); @(negedge clk);
    end
    do_reset("rst_random");
    start_run("rst_op3");
    run_instr("op3", 4'd3, 0, 0, 0);
    n_tests++;
    if (cycle_count !== 32'd6 || instr_count !== 32'd1) begin
      n_fail++;
      $display("FAIL op3_counts: cycle=%0d instr=%0d, expected 6 and 1", cycle_count, instr_count);
    end
  endtask

  task automatic test_opq();
    run_instr("opq6", 4'd6, 0, 0, 0);
    run_instr("cmov2", 4'd2, 0, 0, 0);
    run_instr("jxx7", 4'd7, 0, 0, 0);
  endtask

  task automatic test_mrmovq();
    do_reset("mr_rst");
    start_run("mr_start");
    run_instr("mrmovq", 4'd5, 0, 3, 0);
    n_tests++;
    if (cycle_count !== 32'd9) begin
      n_fail++;
      $display("FAIL mrmovq_cycles: cycle=%0d, expected 9", cycle_count);
    end
    run_instr("rmmov_edge", 4'd4, 0, MEM_TIMEOUT - 1, 0);
  endtask

  task automatic test_mem_faults();
    do_reset("dm_rst");
    start_run("dm_start");
    run_instr("call_derr", 4'd10, 0, 0, 1);
    do_reset("to_rst");
    start_run("to_start");
    run_instr("timeout", 4'd4, 0, 100, 0);
    n_tests++;
    if (cycle_count !== 32'(3 + MEM_TIMEOUT)) begin
      n_fail++;
      $display("FAIL timeout_cycles: cycle=%0d, expected %0d", cycle_count, 3 + MEM_TIMEOUT);
    end
  endtask

  task automatic test_halt_invalid();
    do_reset("hlt_rst");
    start_run("hlt_start");
    run_instr("halt", 4'd0, 0, 0, 0);
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (ens() !== 7'b0 || busy !== 1'b0 || stat !== 3'd2 || cur_icode !== 4'd0) begin
      n_fail++;
      $display("FAIL halt_frozen: en=%b busy=%b stat=%0d icode=%0d, expected 0 0 2 0",
               ens(), busy, stat, cur_icode);
    end
    check_counters("halt_frozen");
    do_reset("ins_rst");
    start_run("ins_start");
    run_instr("ins12", 4'd12, 0, 0, 0);
    do_reset("imem_rst");
    start_run("imem_start");
    run_instr("imem_err", 4'd0, 1, 0, 0);
  endtask

  task automatic test_reset_mid_mem();
    do_reset("mid_rst");
    start_run("mid_start");
    icode = 4'd4; imem_error = 1'b0; mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    n_tests++;
    if (mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mem_en: mem_en=%b, expected 1", mem_en);
    end
    do_reset("mid_async");
    start_run("mid_restart");
    run_instr("mid_after", 4'd9, 0, 2, 0);
  endtask

  task automatic test_random();
    logic [3:0] ic;
    do_reset("rnd_rst");
    start_run("rnd_start");
    for (int n = 0; n < 40 && !m_halted; n++) begin
      ic = 4'($urandom_range(1, 11));
      run_instr("rnd", ic, 0, int'($urandom_range(0, 6)), ($urandom_range(0, 15) == 0));
    end
    if (!m_halted) run_instr("rnd_end", 4'($urandom_range(0, 15)), 1'($urandom), 0, 0);
  endtask

  initial begin
    test_reset();
    test_opq();
    test_mrmovq();
    test_mem_faults();
    test_halt_invalid();
    test_reset_mid_mem();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
